// File: rtl/nes_joypad_port.sv
// NES controller ports at $4016/$4017: HID keycodes drive player 1 through a
// stability filter, switches drive player 2; standard strobe/serial-shift reads.
module nes_joypad_port #(
  parameter int          STABLE_CYCLES = 16,
  parameter logic [7:0]  OPEN_BUS      = 8'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] keycodes,
  input  logic [7:0]  sw_p2,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_dout,
  output logic        cpu_hit,
  output logic [7:0]  buttons_p1
);

  localparam int              CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);

  // Pressing both opposing directions is cleared, as on a real pad's rocker.
  function automatic logic [7:0] lockout(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b[4] && b[5]) r[5:4] = 2'b00;
    if (b[6] && b[7]) r[7:6] = 2'b00;
    return r;
  endfunction

  function automatic logic key_down(input logic [31:0] k, input logic [7:0] code);
    return (k[7:0] == code) || (k[15:8] == code) ||
           (k[23:16] == code) || (k[31:24] == code);
  endfunction

  logic [31:0]   prev_keys;
  logic [CW-1:0] cnt;
  logic [7:0]    mapped;
  logic [7:0]    sw_reg;
  logic [7:0]    sr1;
  logic [7:0]    sr2;
  logic          strobe;
  logic          addr_4016;
  logic          addr_4017;
  logic          strobe_wr;
  logic          shift1;
  logic          shift2;
  logic          sel_bit;
  logic          keys_stable;
  logic          unused_din;

  assign unused_din = ^cpu_din[7:1];

  assign mapped = lockout({key_down(keycodes, 8'h07), key_down(keycodes, 8'h04),
                           key_down(keycodes, 8'h16), key_down(keycodes, 8'h1A),
                           key_down(keycodes, 8'h28), key_down(keycodes, 8'h2C),
                           key_down(keycodes, 8'h0D), key_down(keycodes, 8'h0E)});

  assign addr_4016 = (cpu_addr == 16'h4016);
  assign addr_4017 = (cpu_addr == 16'h4017);
  assign strobe_wr = cpu_we && addr_4016;

  // A read sharing its cycle with a write returns the pre-edge bit and does not shift.
  assign shift1 = cpu_re && addr_4016 && !cpu_we && !strobe;
  assign shift2 = cpu_re && addr_4017 && !cpu_we && !strobe;

  // Load on the edge the counter reaches the limit, and keep loading while saturated.
  assign keys_stable = (keycodes == prev_keys) &&
                       ((cnt == CNT_MAX - 1'b1) || (cnt == CNT_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_keys  <= 32'h0;
      cnt        <= '0;
      buttons_p1 <= 8'h00;
      sw_reg     <= 8'h00;
      strobe     <= 1'b0;
      sr1        <= 8'h00;
      sr2        <= 8'h00;
    end else begin
      prev_keys <= keycodes;
      if (keycodes != prev_keys) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (keys_stable) begin
        buttons_p1 <= mapped;
      end
      sw_reg <= lockout(sw_p2);
      if (strobe_wr) begin
        strobe <= cpu_din[0];
      end
      if (strobe) begin
        sr1 <= buttons_p1;
        sr2 <= sw_reg;
      end else begin
        if (shift1) sr1 <= {1'b1, sr1[7:1]};
        if (shift2) sr2 <= {1'b1, sr2[7:1]};
      end
    end
  end

  // With strobe held the port reports the live A button rather than the shifter.
  always_comb begin
    sel_bit = 1'b0;
    if (addr_4017) begin
      sel_bit = strobe ? sw_reg[0] : sr2[0];
    end else begin
      sel_bit = strobe ? buttons_p1[0] : sr1[0];
    end
  end

  assign cpu_hit  = cpu_re && (addr_4016 || addr_4017);
  assign cpu_dout = cpu_hit ? (OPEN_BUS | {7'b0, sel_bit}) : 8'h00;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Directed self-checking bench for nes_joypad_port: filter latency, serial reads,
// lockout, strobe latching, reset mid-sequence and simultaneous write/read.
module tb_nes_joypad_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] keycodes;
  logic [7:0]  sw_p2;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_dout;
  logic        cpu_hit;
  logic [7:0]  buttons_p1;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] pat;

  nes_joypad_port dut (
    .clk        (clk),
    .reset      (reset),
    .keycodes   (keycodes),
    .sw_p2      (sw_p2),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_dout   (cpu_dout),
    .cpu_hit    (cpu_hit),
    .buttons_p1 (buttons_p1)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic we, input logic re,
                               input logic [15:0] addr, input logic [7:0] din);
    cpu_we   = we;
    cpu_re   = re;
    cpu_addr = addr;
    cpu_din  = din;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic readPort(input string tag, input logic [15:0] addr,
                          input logic [7:0] expected);
    applyStimulus(1'b0, 1'b1, addr, 8'h00);
    checkOutput({tag, "_hit"}, {7'b0, cpu_hit}, 8'h01);
    checkOutput(tag, cpu_dout, expected);
    tick(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic writeStrobe(input logic [15:0] addr, input logic [7:0] din);
    applyStimulus(1'b1, 1'b0, addr, din);
    tick(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  initial begin
    reset    = 1'b1;
    keycodes = 32'h0;
    sw_p2    = 8'h00;
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    tick(2);
    reset = 1'b0;
    #1;
    checkOutput("reset_buttons", buttons_p1, 8'h00);
    checkOutput("reset_hit", {7'b0, cpu_hit}, 8'h00);
    checkOutput("reset_dout", cpu_dout, 8'h00);

    // Filter latency: change lands on edge 1, buttons load on edge 17.
    readPort("first_read", 16'h4016, 8'h40);
    keycodes = 32'h0000000E;
    tick(16);
    checkOutput("filter_16", buttons_p1, 8'h00);
    tick(1);
    checkOutput("filter_17", buttons_p1, 8'h01);

    keycodes = 32'h001A0D28;
    tick(17);
    checkOutput("map_ubs", buttons_p1, 8'h1A);
    writeStrobe(16'h4016, 8'h01);
    writeStrobe(16'h4016, 8'h00);
    pat = 8'h1A;
    for (int i = 0; i < 8; i++) readPort("p1_serial", 16'h4016, 8'h40 | {7'b0, pat[i]});
    readPort("p1_read9", 16'h4016, 8'h41);
    readPort("p1_read10", 16'h4016, 8'h41);

    // Keys that never hold long enough must not reach the button state.
    keycodes = 32'h0;
    tick(20);
    checkOutput("release", buttons_p1, 8'h00);
    for (int i = 0; i < 6; i++) begin
      keycodes = (i % 2 == 0) ? 32'h0000000E : 32'h0;
      tick(10);
      checkOutput("toggle", buttons_p1, 8'h00);
    end

    keycodes = 32'h0E041A16;
    tick(17);
    checkOutput("lock_ud", buttons_p1, 8'h41);
    keycodes = 32'h07041A16;
    tick(17);
    checkOutput("lock_all", buttons_p1, 8'h00);

    sw_p2 = 8'h30;
    tick(1);
    writeStrobe(16'h4016, 8'h01);
    writeStrobe(16'h4016, 8'h00);
    for (int i = 0; i < 8; i++) readPort("p2_lock", 16'h4017, 8'h40);
    sw_p2 = 8'h89;
    tick(1);
    writeStrobe(16'h4016, 8'h01);
    writeStrobe(16'h4016, 8'h00);
    writeStrobe(16'h4017, 8'h01);
    pat = 8'h89;
    for (int i = 0; i < 8; i++) readPort("p2_serial", 16'h4017, 8'h40 | {7'b0, pat[i]});
    applyStimulus(1'b0, 1'b1, 16'h4018, 8'h00);
    checkOutput("miss_hit", {7'b0, cpu_hit}, 8'h00);
    checkOutput("miss_dout", cpu_dout, 8'h00);
    tick(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);

    // Strobe held: reads report live A; falling strobe freezes the snapshot.
    keycodes = 32'h0000000E;
    tick(17);
    checkOutput("a_held", buttons_p1, 8'h01);
    writeStrobe(16'h4016, 8'h01);
    for (int i = 0; i < 3; i++) readPort("strobe_read", 16'h4016, 8'h41);
    writeStrobe(16'h4016, 8'h00);
    keycodes = 32'h0;
    tick(20);
    checkOutput("a_released", buttons_p1, 8'h00);
    readPort("latched_a", 16'h4016, 8'h41);
    readPort("latched_b", 16'h4016, 8'h40);

    keycodes = 32'h00002C0D;
    tick(17);
    checkOutput("map_bsel", buttons_p1, 8'h06);
    writeStrobe(16'h4016, 8'h01);
    writeStrobe(16'h4016, 8'h00);
    readPort("pre_reset0", 16'h4016, 8'h40);
    readPort("pre_reset1", 16'h4016, 8'h41);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_buttons", buttons_p1, 8'h00);
    readPort("post_reset", 16'h4016, 8'h40);
    tick(18);
    checkOutput("refilter", buttons_p1, 8'h06);

    // Write and read together: pre-edge bit returned, no shift.
    applyStimulus(1'b1, 1'b1, 16'h4016, 8'h01);
    checkOutput("wr_rd_set", cpu_dout, 8'h40);
    tick(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    readPort("strobe_live", 16'h4016, 8'h40);
    writeStrobe(16'h4016, 8'h00);
    readPort("reload0", 16'h4016, 8'h40);
    applyStimulus(1'b1, 1'b1, 16'h4016, 8'h00);
    checkOutput("wr_rd_clr", cpu_dout, 8'h41);
    tick(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    readPort("noshift1", 16'h4016, 8'h41);
    readPort("noshift2", 16'h4016, 8'h41);
    readPort("noshift3", 16'h4016, 8'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nes_joypad_port.md
Name: nes_joypad_port

Overview:
- NES controller-port emulation for CPU registers $4016/$4017. It sits upstream of the CPU data bus, beside the PPU register path, in the clk_CPU domain.
- Converts four USB HID keycodes (MicroBlaze GPIO word, already retimed into clk_CPU) into player-1 buttons, and switch inputs into player-2 buttons.
- Presents the standard strobe/serial-shift read protocol to the 6502 core.

Parameters:
- STABLE_CYCLES, 16: consecutive cycles the keycode word must hold unchanged before the P1 button state updates.
- OPEN_BUS, 8'h40: value OR-ed into the upper bits of every port read.

Ports:
- clk  in  1  CPU clock (clk_CPU)
- reset  in  1  synchronous, active-high
- keycodes  in  32  four HID keycodes, byte0 = [7:0]; 8'h00 = empty slot
- sw_p2  in  8  player-2 buttons, active-high, order A,B,Sel,Start,Up,Down,Left,Right = bit0..7
- cpu_addr  in  16  CPU address
- cpu_din  in  8  CPU write data
- cpu_we  in  1  single-cycle write strobe
- cpu_re  in  1  single-cycle read strobe
- cpu_dout  out  8  read data
- cpu_hit  out  1  high when cpu_re and cpu_addr is $4016 or $4017
- buttons_p1  out  8  filtered P1 button state (debug/hex display)

Behaviour:
- Key map, with a button pressed if any of the 4 keycode bytes matches:
  - A = 8'h0E (K), B = 8'h0D (J), Select = 8'h2C (Space), Start = 8'h28 (Enter)
  - Up = 8'h1A (W), Down = 8'h16 (S), Left = 8'h04 (A), Right = 8'h07 (D)
  - Duplicate codes are harmless; unknown codes are ignored.
- Opposing-direction lockout on the mapped P1 value and on sw_p2:
  - Up and Down both set: both cleared.
  - Left and Right both set: both cleared.
- Stability filter:
  - A 32-bit previous-keycode register and a counter (width = clog2(STABLE_CYCLES+1)).
  - When keycodes differs from the previous value, the counter resets to 0.
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
  - On the cycle the counter reaches STABLE_CYCLES, buttons_p1 loads the mapped value.
  - Update latency is STABLE_CYCLES+1 cycles after the last change.
  - sw_p2 is registered once, with no filter.
- Strobe register, bit0 of the last write to $4016:
  - A write to $4017 is ignored here (APU frame counter, not this block).
- Shift registers sr1 and sr2, 8 bits each, bit0 = next bit out:
  - While strobe=1, every cycle loads sr1 = buttons_p1 and sr2 = sw_p2 (after lockout).
  - While strobe=0, a cpu_re to $4016 shifts sr1 right with 1 entering bit7; a read of $4017 does the same to sr2.
  - The shift takes effect at the clock edge ending the read cycle.
  - After 8 reads, bit0 = 1 forever until the next reload.
  - While strobe=1, reads do not shift and always return the current A button.
- The strobe 1->0 write latches the button state present at that edge; later button changes are not visible until the next strobe.
- cpu_dout is combinational:
  - cpu_hit=1: OPEN_BUS | {7'b0, sel_sr[0]}.
  - Otherwise 8'h00.
- Write and read in the same cycle: the write is applied and the read returns the pre-edge bit with no shift.
- Address decode is the full 16-bit compare; mirrors are not decoded.
- Reset:
  - strobe=0; sr1=sr2=8'h00; buttons_p1=8'h00; previous-keycode register = 0; counter = 0.
  - cpu_dout=8'h00 and cpu_hit=0 unless a read is presented.
  - Reset mid-sequence abandons the shift position immediately.

Test Plan:
- Reset, then read $4016 → cpu_hit=1, cpu_dout=8'h40. Hold keycodes=32'h0000000E for 16 cycles, check buttons_p1 is still 8'h00; at cycle 17 it becomes 8'h01.
- Stable keycodes=32'h001A0D28 (Up, B, Start); write $4016=1 then =0; 8 reads → bits 0,1,0,1,1,0,0,0; 9th and 10th reads → 8'h41.
- Keycodes toggled every 10 cycles between 0 and 32'h0E → buttons_p1 never changes from 8'h00.
- keycodes=32'h07041A16 (all four directions) → buttons_p1=8'h00. sw_p2=8'h30 (Up+Down) → reads of $4017 return bit0..7 all 0.
- With strobe=1 and A held, 3 reads of $4016 → 8'h41 each time with no shift. Then clear strobe, change keys to none; first read → 8'h41 (latched value).
- Read $4016 twice after the strobe, then assert reset for one cycle, then read → 8'h40. A simultaneous write $4016=1 and read → pre-edge bit returned, sr1 reloaded next cycle.
